// File: rtl/restore_tile_if.sv
// Tile-restore bus: controller handshake, background-map read port and VGA pixel stream.
interface restore_tile_if #(
    parameter int COLOUR_W = 9,
    parameter int ADDR_W   = 15
);
    logic                start;
    logic [3:0]          grid_x;
    logic [3:0]          grid_y;
    logic [COLOUR_W-1:0] bg_q;
    logic [ADDR_W-1:0]   bg_addr;
    logic [7:0]          x;
    logic [6:0]          y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                busy;
    logic                done;

    modport master (
        output start, grid_x, grid_y, bg_q,
        input  bg_addr, x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, grid_x, grid_y, bg_q,
        output bg_addr, x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/restore_tile_from_map.sv
// Redraws one 20x20 tile from the 160x120 background map RAM as a VGA pixel stream.
module restore_tile_from_map #(
    parameter int TILE     = 20,
    parameter int GRID_W   = 8,
    parameter int GRID_H   = 6,
    parameter int SCREEN_W = 160,
    parameter int COLOUR_W = 9,
    parameter int ADDR_W   = 15
) (
    input  logic           clk,
    input  logic           resetn,
    restore_tile_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_gx, r_gy;
    logic [4:0] r_cx, r_cy;
    logic [7:0] r_x;
    logic [6:0] r_y;
    logic       r_plot, r_busy, r_done;

    logic [7:0]        w_tx, w_px;
    logic [6:0]        w_ty, w_py;
    logic [ADDR_W-1:0] w_addr;
    logic              w_accept, w_cx_last, w_cy_last;

    // Tile origin: g*20 built from shifts so no multiplier is inferred.
    assign w_tx = ({4'b0, r_gx} << 4) + ({4'b0, r_gx} << 2);
    assign w_ty = ({3'b0, r_gy} << 4) + ({3'b0, r_gy} << 2);
    assign w_px = w_tx + {3'b0, r_cx};
    assign w_py = w_ty + {2'b0, r_cy};

    generate
        if (SCREEN_W == 160) begin : g_stride_160
            assign w_addr = (ADDR_W'(w_py) << 7) + (ADDR_W'(w_py) << 5) + ADDR_W'(w_px);
        end else begin : g_stride_generic
            assign w_addr = ADDR_W'(w_py) * ADDR_W'(SCREEN_W) + ADDR_W'(w_px);
        end
    endgenerate

    assign w_accept  = bus.start && (bus.grid_x < 4'(GRID_W)) && (bus.grid_y < 4'(GRID_H));
    assign w_cx_last = (r_cx == 5'(TILE - 1));
    assign w_cy_last = (r_cy == 5'(TILE - 1));

    // Counters freeze on the last pixel, so bg_addr holds through DRAIN.
    assign bus.bg_addr = w_addr;
    assign bus.x       = r_x;
    assign bus.y       = r_y;
    assign bus.colour  = bus.bg_q;
    assign bus.plot    = r_plot;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_gx    <= '0;
            r_gy    <= '0;
            r_cx    <= '0;
            r_cy    <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_plot  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_plot <= 1'b0;
                    if (w_accept) begin
                        r_gx    <= bus.grid_x;
                        r_gy    <= bus.grid_y;
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    // Pixel coordinates trail the address by one cycle to meet the RAM data.
                    r_x    <= w_px;
                    r_y    <= w_py;
                    r_plot <= 1'b1;
                    if (w_cx_last) begin
                        if (w_cy_last) begin
                            r_state <= DRAIN;
                        end else begin
                            r_cx <= '0;
                            r_cy <= r_cy + 5'd1;
                        end
                    end else begin
                        r_cx <= r_cx + 5'd1;
                    end
                end
                DRAIN: begin
                    r_plot  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                DONE: begin
                    r_plot  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_restore_tile_from_map.sv
// Bench for restore_tile_from_map: per-cycle comparison against a raster-order tile model.
module tb_restore_tile_from_map;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    restore_tile_if #(.COLOUR_W(9), .ADDR_W(15)) bus ();

    restore_tile_from_map dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Background map contents: distinct-ish colour per address, 0 at address 0.
    function automatic logic [8:0] map_col(input logic [14:0] a);
        return a[8:0] ^ {3'b0, a[14:9]};
    endfunction

    // Single-port map RAM with one-cycle read latency.
    always @(posedge clk) bus.bg_q <= map_col(bus.bg_addr);

    // Accept start in cycle 0, then compare every cycle 1..402 (or up to 5 past an abort).
    // pa/pb: extra start pulses to be ignored; ab: cycle in which resetn is held low (0 = none).
    task automatic run_tile(input int gx, input int gy, input int pa, input int pb,
                            input int ab, input string nm);
        int last, nplot, ndone, p, q, ex, ey, ea;
        logic aborted, ep, eb, ed, am, cxy;
        logic [8:0]  ecol;
        logic [41:0] e, a;
        last  = (ab > 0) ? ab + 5 : 402;
        nplot = 0;
        ndone = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.grid_x = 4'(gx);
        bus.grid_y = 4'(gy);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            aborted = (ab > 0) && (k > ab);
            ep  = !aborted && k >= 2 && k <= 401;
            eb  = !aborted && k >= 1 && k <= 401;
            ed  = !aborted && k == 402;
            am  = aborted || (k >= 1 && k <= 401);
            cxy = ep || aborted;
            p   = k - 2;
            ex  = ep ? gx * 20 + p % 20 : 0;
            ey  = ep ? gy * 20 + p / 20 : 0;
            ecol = ep ? map_col(15'(ey * 160 + ex)) : 9'd0;
            q   = (k - 1 > 399) ? 399 : k - 1;
            ea  = aborted ? 0 : (gy * 20 + q / 20) * 160 + gx * 20 + q % 20;
            e = {ep, eb, ed, 8'(ex), 7'(ey), ecol, am ? 15'(ea) : 15'd0};
            a = {bus.plot, bus.busy, bus.done,
                 cxy ? bus.x : 8'd0, cxy ? bus.y : 7'd0,
                 ep ? bus.colour : 9'd0, am ? bus.bg_addr : 15'd0};
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s cycle=%0d got{plot,busy,done,x,y,col,addr}=%h expected=%h",
                         nm, k, a, e);
            end
            if (bus.plot === 1'b1) nplot++;
            if (bus.done === 1'b1) ndone++;
            bus.start = (k == pa) || (k == pb);
            resetn    = (k != ab);
        end
        checks++;
        if (nplot !== ((ab > 0) ? ab - 1 : 400)) begin
            failures++;
            $display("FAIL %s plot_count got=%0d expected=%0d", nm, nplot,
                     (ab > 0) ? ab - 1 : 400);
        end
        checks++;
        if (ndone !== ((ab > 0) ? 0 : 1)) begin
            failures++;
            $display("FAIL %s done_count got=%0d expected=%0d", nm, ndone, (ab > 0) ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        bus.start  = 1'b1;
        bus.grid_x = 4'd0;
        bus.grid_y = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.bg_addr} !== 33'd0) begin
                failures++;
                $display("FAIL reset cycle=%0d got plot=%b busy=%b done=%b x=%0d y=%0d addr=%0d expected all 0",
                         i, bus.plot, bus.busy, bus.done, bus.x, bus.y, bus.bg_addr);
            end
        end
        resetn    = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release got plot/busy/done=%b%b%b expected 000",
                     bus.plot, bus.busy, bus.done);
        end
    endtask

    task automatic test_out_of_range();
        int bx [3];
        int by [3];
        bx[0] = 8;  by[0] = 0;
        bx[1] = 0;  by[1] = 6;
        bx[2] = $urandom_range(8, 15); by[2] = $urandom_range(6, 15);
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.start  = 1'b1;
            bus.grid_x = 4'(bx[t]);
            bus.grid_y = 4'(by[t]);
            for (int k = 1; k <= 4; k++) begin
                @(negedge clk);
                bus.start = 1'b0;
                checks++;
                if ({bus.plot, bus.busy, bus.done} !== 3'b000) begin
                    failures++;
                    $display("FAIL out_of_range gx=%0d gy=%0d cycle=%0d got plot/busy/done=%b%b%b expected 000",
                             bx[t], by[t], k, bus.plot, bus.busy, bus.done);
                end
            end
        end
    endtask

    task automatic test_random();
        int gx, gy, pa, pb;
        for (int r = 0; r < 3; r++) begin
            gx = $urandom_range(0, 7);
            gy = $urandom_range(0, 5);
            pa = $urandom_range(1, 400);
            pb = $urandom_range(401, 402);
            run_tile(gx, gy, pa, pb, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        run_tile(0, 0, -1, -1, 0, "tile_0_0");
        run_tile(7, 5, -1, -1, 0, "tile_7_5");
        test_out_of_range();
        run_tile(3, 2, 50, 402, 0, "start_while_busy");
        run_tile(1, 4, -1, -1, 0, "start_after_done");
        run_tile(2, 2, -1, -1, 100, "abort");
        run_tile(2, 2, -1, -1, 0, "after_abort");
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
